posit_add_arbiter: RTL

//  Round-robin scheduler sharing one fully pipelined posit_adder_8 among NREQ requesters.
//  It accepts at most one add per cycle and registers the operands into the adder.

---
 rtl/posit_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/posit_add_arbiter.sv | 83 ++++++++
 3 files changed

// File: rtl/posit_pkg.sv
// posit_pkg: shared posit constants and the issue tag carried alongside the adder pipeline
package posit_pkg;
    localparam int POSIT_N  = 8;
    localparam int POSIT_ES = 4;
    localparam logic [POSIT_N-1:0] POSIT_NAR  = {1'b1, {(POSIT_N-1){1'b0}}};
    localparam logic [POSIT_N-1:0] POSIT_ZERO = '0;
    typedef struct packed {
        logic       valid;
        logic [3:0] id;
    } tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant, search starts at ptr and wraps modulo NREQ
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);
    logic [IDW-1:0] j;
    always_comb begin
        j   = '0;
        idx = '0;
        any = 1'b0;
        // scan from the far end so the candidate nearest ptr wins
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = IDW'((int'(ptr) + i) % NREQ);
            if (req[j]) begin
                idx = j;
                any = 1'b1;
            end
        end
        grant = any ? NREQ'(1) << idx : '0;
    end
endmodule

// File: rtl/posit_add_arbiter.sv
// posit_add_arbiter: round-robin front end sharing one pipelined posit adder among NREQ requesters
module posit_add_arbiter
    import posit_pkg::*;
#(
    parameter int N       = POSIT_N,
    parameter int ES      = POSIT_ES,
    parameter int NREQ    = 4,
    parameter int LATENCY = 8,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_in1,
    input  logic [NREQ*N-1:0] req_in2,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [N-1:0]      rsp_result,
    output logic              rsp_inf,
    output logic              rsp_zero,
    output logic              add_start,
    output logic [N-1:0]      add_in1,
    output logic [N-1:0]      add_in2,
    input  logic [N-1:0]      add_result,
    input  logic              add_inf,
    input  logic              add_zero,
    output logic [IDW+1:0]    inflight,
    output logic [15:0]       issue_cnt
);
    localparam int IFW = IDW + 2;
    if (NREQ < 2 || NREQ > 16 || ES >= N) begin : g_bad_cfg
        $error("posit_add_arbiter: unsupported configuration");
    end
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  idx;
    logic [IDW-1:0]  rr_ptr;
    logic            any;
    logic [N-1:0]    in1_arr [NREQ];
    logic [N-1:0]    in2_arr [NREQ];
    tag_t            tags [0:LATENCY];
    tag_t            tail;
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign in1_arr[g] = req_in1[g*N +: N];
        assign in2_arr[g] = req_in2[g*N +: N];
    end
    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (idx),
        .any   (any)
    );
    assign req_ready = aresetn ? grant : '0;
    // tags[0] sits beside add_in*, so tags[LATENCY] lines up with add_result
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            add_in1   <= '0;
            add_in2   <= '0;
            add_start <= 1'b0;
            rr_ptr    <= '0;
            inflight  <= '0;
            issue_cnt <= '0;
            for (int i = 0; i <= LATENCY; i++) tags[i] <= '0;
        end else begin
            add_start <= 1'b1;
            if (any) begin
                add_in1   <= in1_arr[idx];
                add_in2   <= in2_arr[idx];
                rr_ptr    <= idx == IDW'(NREQ - 1) ? '0 : idx + 1'b1;
                issue_cnt <= issue_cnt + 16'd1;
            end
            tags[0] <= '{valid: any, id: 4'(idx)};
            for (int i = 1; i <= LATENCY; i++) tags[i] <= tags[i-1];
            // an op stops counting once its tag reaches the tail, where it is delivered
            inflight <= inflight + IFW'(any) - IFW'(tags[LATENCY-1].valid);
        end
    end
    assign tail       = tags[LATENCY];
    assign rsp_valid  = tail.valid ? NREQ'(1) << tail.id : '0;
    assign rsp_result = tail.valid ? add_result : '0;
    assign rsp_inf    = tail.valid & add_inf;
    assign rsp_zero   = tail.valid & add_zero;
endmodule
